// File: rtl/sdu_host_pkg.sv
// sdu_host_pkg: shared state types, ASCII constants and hex helper for the debug-host initiator
package sdu_host_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEND_CMD, S_SEND_SP, S_SEND_HEX, S_SEND_CR, S_WAIT_RSP} host_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] PROMPT_DEFAULT = 8'h3E;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and framing check
module uart_rx_core import sdu_host_pkg::*; #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_strobe
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  rx_state_t st;
  logic rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_meta, rx_sync, rx_prev} <= 3'b111;
      st <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      rx_byte <= '0;
      rx_strobe <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      rx_strobe <= 1'b0;
      cnt <= cnt + CW'(1);
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) st <= RX_START;
        end
        RX_START: if (cnt == HALF) begin
          cnt <= '0;
          st <= rx_sync ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == FULL) begin
          cnt <= '0;
          sh <= {rx_sync, sh[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) st <= RX_STOP;
        end
        RX_STOP: if (cnt == FULL) begin
          st <= RX_IDLE;
          rx_strobe <= rx_sync;
          if (rx_sync) rx_byte <= sh;
        end
        default: st <= RX_IDLE;
      endcase
    end
endmodule

// File: rtl/sdu_cmd_initiator.sv
// sdu_cmd_initiator: UART debug-host command sender/response collector; define SDU_HOST_ECHO_DROP_EN to drop pre-CR echo bytes
module sdu_cmd_initiator import sdu_host_pkg::*; #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0] PROMPT_CHAR = PROMPT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_char,
  input  logic        cmd_has_arg,
  input  logic [31:0] cmd_arg,
  output logic        txd,
  input  logic        rxd,
  output logic        rsp_valid,
  output logic [7:0]  rsp_byte,
  output logic        rsp_done,
  output logic        rsp_timeout,
  output logic        busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  host_state_t state, next_state;
  logic has_arg, fwd, rx_strobe;
  logic [31:0] arg_sh;
  logic [2:0] hex_idx;
  logic [8:0] frame;
  logic [3:0] bit_idx;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0] rx_byte, next_byte;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_byte(rx_byte), .rx_strobe(rx_strobe)
  );
  assign cmd_ready = state == S_IDLE;
  assign busy = !cmd_ready;
`ifdef SDU_HOST_ECHO_DROP_EN
  assign fwd = state == S_WAIT_RSP;
`else
  assign fwd = state != S_IDLE;
`endif
  always_comb begin
    next_state = (state == S_SEND_CMD) ? (has_arg ? S_SEND_SP : S_SEND_CR)
               : (state == S_SEND_SP || (state == S_SEND_HEX && hex_idx != 3'd7)) ? S_SEND_HEX
               : (state == S_SEND_HEX) ? S_SEND_CR : S_WAIT_RSP;
    next_byte = (next_state == S_SEND_SP) ? ASCII_SP
              : (next_state == S_SEND_HEX) ? nibble_to_ascii(arg_sh[31:28]) : ASCII_CR;
  end
  // frame holds {stop, data}; the start bit is driven directly when a frame is loaded
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      txd <= 1'b1;
      has_arg <= 1'b0;
      arg_sh <= '0;
      hex_idx <= '0;
      frame <= '0;
      bit_idx <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_byte <= '0;
      rsp_done <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= rx_strobe && fwd;
      if (rx_strobe && fwd) rsp_byte <= rx_byte;
      rsp_done <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          state <= S_SEND_CMD;
          has_arg <= cmd_has_arg;
          arg_sh <= cmd_arg;
          hex_idx <= '0;
          frame <= {1'b1, cmd_char};
          txd <= 1'b0;
          bit_idx <= '0;
          bit_cnt <= '0;
        end
        S_WAIT_RSP: begin
          tmo_cnt <= rx_strobe ? '0 : tmo_cnt + TW'(1);
          if (rx_strobe && rx_byte == PROMPT_CHAR) begin
            rsp_done <= 1'b1;
            state <= S_IDLE;
          end else if (tmo_cnt == TLAST) begin
            rsp_timeout <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: if (bit_cnt != FULL) bit_cnt <= bit_cnt + BW'(1);
        else begin
          bit_cnt <= '0;
          if (bit_idx != 4'd9) begin
            bit_idx <= bit_idx + 4'd1;
            txd <= frame[bit_idx];
          end else begin
            state <= next_state;
            bit_idx <= '0;
            frame <= {1'b1, next_byte};
            txd <= next_state == S_WAIT_RSP;
            tmo_cnt <= '0;
            if (next_state == S_SEND_HEX) begin
              arg_sh <= arg_sh << 4;
              hex_idx <= (state == S_SEND_HEX) ? hex_idx + 3'd1 : 3'd0;
            end
          end
        end
      endcase
    end
endmodule

// File: tb/tb_sdu_cmd_initiator.sv
// tb_sdu_cmd_initiator: randomized self-checking bench with a cycle-level behavioural model
`timescale 1ns/1ps
module tb_sdu_cmd_initiator;
  localparam int CPB = 4;
  localparam int TMO = 200;
  localparam int FR = 10 * CPB;
  logic clk = 0, rst = 0, cmd_valid = 0, cmd_has_arg = 0, rxd = 1;
  logic [7:0] cmd_char = '0;
  logic [31:0] cmd_arg = '0;
  logic cmd_ready, txd, rsp_valid, rsp_done, rsp_timeout, busy;
  logic [7:0] rsp_byte;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] tx_bytes [12];
  logic [7:0] cap [12];
  int tx_n = 0, tx_a = -100000, ends = 0;
  bit tx_on = 0, tmo_exp = 0, last_tmo = 0, end_prev = 0;
  logic [7:0] exp_q [$];
  logic [7:0] plan [$];

  sdu_cmd_initiator #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .PROMPT_CHAR(8'h3E)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_char(cmd_char),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg), .txd(txd), .rxd(rxd), .rsp_valid(rsp_valid),
    .rsp_byte(rsp_byte), .rsp_done(rsp_done), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    int d;
    d = int'(n);
    return 8'(d < 10 ? 48 + d : 65 + d - 10);
  endfunction

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom);
    return b == 8'h3E ? 8'h3F : b;
  endfunction

  // expected txd: window j after the accepting edge carries bit (j%FR)/CPB of frame j/FR
  function automatic logic exp_txd(input int j);
    int b;
    if (!tx_on || j < 0 || j >= tx_n * FR) return 1'b1;
    b = (j % FR) / CPB;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : tx_bytes[j / FR][b - 1];
  endfunction

  always @(negedge clk) begin
    int j, b;
    logic [7:0] e;
    if (!rst) begin
      j = cyc - tx_a;
      b = (j % FR) / CPB;
      chk("txd", txd, exp_txd(j));
      chk("busy", busy, !cmd_ready);
      if (tx_on && j >= 0 && j <= tx_n * FR) chk("ready_low", cmd_ready, 0);
      chk("rsp_timeout", rsp_timeout, tmo_exp && j == tx_n * FR + TMO);
      if (tx_on && j >= 0 && j < tx_n * FR && j % CPB == CPB / 2 && b >= 1 && b <= 8)
        cap[j / FR][b - 1] = txd;
      if (end_prev) chk("ready_after_end", cmd_ready, 1);
      end_prev = rsp_done || rsp_timeout;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_extra: got %0h, want no byte (cycle %0d)", rsp_byte, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_byte", rsp_byte, e);
          chk("rsp_done", rsp_done, e == 8'h3E);
        end
      end else chk("rsp_done_alone", rsp_done, 0);
      if (rsp_done || rsp_timeout) begin
        ends++;
        last_tmo = rsp_timeout;
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] c, input bit h, input logic [31:0] a, input bit to);
    logic [31:0] s;
    s = a;
    @(negedge clk);
    #1;
    tx_bytes[0] = c;
    tx_n = 1;
    if (h) begin
      tx_bytes[tx_n] = 8'h20;
      tx_n++;
      for (int i = 0; i < 8; i++) begin
        tx_bytes[tx_n] = hexc(s[31:28]);
        tx_n++;
        s = s << 4;
      end
    end
    tx_bytes[tx_n] = 8'h0D;
    tx_n++;
    cmd_char = c;
    cmd_has_arg = h;
    cmd_arg = a;
    cmd_valid = 1'b1;
    tmo_exp = to;
    tx_a = cyc + 1;
    tx_on = 1'b1;
    @(negedge clk);
    #1;
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_char = 8'($urandom);
    cmd_has_arg = 1'($urandom_range(0, 1));
    cmd_arg = $urandom;
  endtask

  task automatic end_txn(input int e0);
    int k;
    k = 0;
    while (ends == e0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("txn_end_seen", ends != e0, 1);
    chk("end_kind_timeout", last_tmo, tmo_exp);
    chk("rsp_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic txn(input logic [7:0] c, input bit h, input logic [31:0] a, input bit echo, input bit ferr, input bit to);
    int e0;
    logic [7:0] b;
    e0 = ends;
    issue(c, h, a, to);
    if (echo) begin
      b = rnd_byte();
`ifndef SDU_HOST_ECHO_DROP_EN
      exp_q.push_back(b);
`endif
      uart_send(b, 1'b1);
    end
    wait_until(tx_a + tx_n * FR);
    #1;
    cmd_valid = 1'b0;
    if (!to) begin
      if (ferr) uart_send(rnd_byte(), 1'b0);
      while (plan.size() > 0) begin
        b = plan.pop_front();
        exp_q.push_back(b);
        uart_send(b, 1'b1);
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    end_txn(e0);
  endtask

  initial begin
    logic [7:0] lit_p [2];
    logic [7:0] lit_d [11];
    int n;
    bit to;
    lit_p = '{8'h50, 8'h0D};
    lit_d = '{8'h44, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D};
    #1 rst = 1'b1;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_done", rsp_done, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_byte", rsp_byte, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    plan = '{8'h31, 8'h32, 8'h0D, 8'h0A, 8'h3E};
    txn(8'h50, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) chk("cap_p", cap[i], lit_p[i]);

    plan.delete();
    txn(8'h44, 1'b1, 32'h0000_1A2F, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) chk("cap_d", cap[i], lit_d[i]);

    plan = '{8'h3E};
    txn(8'h58, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    issue(8'h44, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_until(tx_a + 3 * FR + 10);
    #2;
    rst = 1'b1;
    cmd_valid = 1'b0;
    tx_on = 1'b0;
    tmo_exp = 1'b0;
    tx_a = -100000;
    exp_q.delete();
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    plan = '{8'h41, 8'h3E};
    txn(8'h52, 1'b1, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 4);
      to = $urandom_range(0, 3) == 0;
      plan.delete();
      if (!to) begin
        for (int i = 0; i < n; i++) plan.push_back(rnd_byte());
        plan.push_back(8'h3E);
      end
      txn(8'($urandom_range(33, 126)), 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 1) == 1, !to && $urandom_range(0, 2) == 0, to);
    end
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end
endmodule
